// File: rtl/core_pkg.sv
// Shared definitions for the 5-stage core: ALU op encodings, control bundle and
// the bubble value loaded into pipeline registers when an instruction is squashed.
package core_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_NOR = 4'd5,
        ALU_SLT = 4'd6,
        ALU_SLL = 4'd7,
        ALU_SRL = 4'd8,
        ALU_SRA = 4'd9,
        ALU_LUI = 4'd10
    } alu_op_e;

    typedef struct packed {
        logic       reg_wen;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic [3:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '{
        reg_wen:    1'b0,
        mem_read:   1'b0,
        mem_write:  1'b0,
        mem_to_reg: 1'b0,
        alu_src:    1'b0,
        alu_op:     ALU_ADD
    };

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check: a load in EX whose destination is read
// by the instruction currently in ID cannot be forwarded in time.
module load_use_detect
    import core_pkg::*;
(
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    output logic       lu_hit
);

    // $0 is hardwired, so a load targeting it never creates a dependency.
    assign lu_hit = ex_mem_read && (ex_rt != REG_ZERO) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and a saturating count
// of inserted load-use bubbles.
module id_ex_stage
    import core_pkg::*;
#(
    parameter int          DW      = 32,
    parameter logic [15:0] SAT_MAX = 16'hFFFF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [4:0]    id_rs,
    input  logic [4:0]    id_rt,
    input  logic [4:0]    id_rd,
    input  logic          id_uses_rt,
    input  logic [DW-1:0] id_a,
    input  logic [DW-1:0] id_b,
    input  logic [DW-1:0] id_imm,
    input  logic          id_reg_wen,
    input  logic          id_mem_read,
    input  logic          id_mem_write,
    input  logic          id_mem_to_reg,
    input  logic          id_alu_src,
    input  logic [3:0]    id_alu_op,
    input  logic          flush,
    input  logic          hold,
    output logic [4:0]    ex_rs,
    output logic [4:0]    ex_rt,
    output logic [4:0]    ex_rd,
    output logic [DW-1:0] ex_a,
    output logic [DW-1:0] ex_b,
    output logic [DW-1:0] ex_imm,
    output logic          ex_reg_wen,
    output logic          ex_mem_read,
    output logic          ex_mem_write,
    output logic          ex_mem_to_reg,
    output logic          ex_alu_src,
    output logic [3:0]    ex_alu_op,
    output logic          lu_stall,
    output logic [15:0]   stall_count
);

    ctrl_t id_ctrl;
    ctrl_t ex_ctrl;
    logic  lu_hit;

    assign id_ctrl = '{
        reg_wen:    id_reg_wen,
        mem_read:   id_mem_read,
        mem_write:  id_mem_write,
        mem_to_reg: id_mem_to_reg,
        alu_src:    id_alu_src,
        alu_op:     id_alu_op
    };

    load_use_detect u_load_use_detect (
        .ex_mem_read (ex_ctrl.mem_read),
        .ex_rt       (ex_rt),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .lu_hit      (lu_hit)
    );

    // A flush already squashes ID, and a hold freezes everything, so neither needs a stall.
    assign lu_stall = lu_hit && !flush && !hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_rs       <= REG_ZERO;
            ex_rt       <= REG_ZERO;
            ex_rd       <= REG_ZERO;
            ex_a        <= '0;
            ex_b        <= '0;
            ex_imm      <= '0;
            ex_ctrl     <= CTRL_BUBBLE;
            stall_count <= '0;
        end else if (!hold) begin
            if (flush || lu_hit) begin
                // rd=0 with wen=0 keeps the bubble invisible to forwarding.
                ex_rs   <= REG_ZERO;
                ex_rt   <= REG_ZERO;
                ex_rd   <= REG_ZERO;
                ex_a    <= '0;
                ex_b    <= '0;
                ex_imm  <= '0;
                ex_ctrl <= CTRL_BUBBLE;
                if (!flush && (stall_count != SAT_MAX))
                    stall_count <= stall_count + 16'd1;
            end else begin
                ex_rs   <= id_rs;
                ex_rt   <= id_rt;
                ex_rd   <= id_rd;
                ex_a    <= id_a;
                ex_b    <= id_b;
                ex_imm  <= id_imm;
                ex_ctrl <= id_ctrl;
            end
        end
    end

    assign ex_reg_wen    = ex_ctrl.reg_wen;
    assign ex_mem_read   = ex_ctrl.mem_read;
    assign ex_mem_write  = ex_ctrl.mem_write;
    assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
    assign ex_alu_src    = ex_ctrl.alu_src;
    assign ex_alu_op     = ex_ctrl.alu_op;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table for the per-edge priority, plus
// hand sequences for asynchronous reset and counter saturation.
module tb_id_ex_stage;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    id_rs, id_rt, id_rd;
    logic          id_uses_rt;
    logic [DW-1:0] id_a, id_b, id_imm;
    logic          id_reg_wen, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src;
    logic [3:0]    id_alu_op;
    logic          flush, hold;

    logic [4:0]    ex_rs, ex_rt, ex_rd;
    logic [DW-1:0] ex_a, ex_b, ex_imm;
    logic          ex_reg_wen, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src;
    logic [3:0]    ex_alu_op;
    logic          lu_stall;
    logic [15:0]   stall_count;

    // Second instance with a low saturation point so the limit is reachable quickly.
    logic [4:0]    s_rs, s_rt, s_rd;
    logic [DW-1:0] s_a, s_b, s_imm;
    logic          s_reg_wen, s_mem_read, s_mem_write, s_mem_to_reg, s_alu_src;
    logic [3:0]    s_alu_op;
    logic          s_lu_stall;
    logic [15:0]   s_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
        .id_a(id_a), .id_b(id_b), .id_imm(id_imm),
        .id_reg_wen(id_reg_wen), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
        .flush(flush), .hold(hold),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
        .ex_reg_wen(ex_reg_wen), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
        .lu_stall(lu_stall), .stall_count(stall_count)
    );

    id_ex_stage #(.DW(DW), .SAT_MAX(16'd5)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
        .id_a(id_a), .id_b(id_b), .id_imm(id_imm),
        .id_reg_wen(id_reg_wen), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
        .flush(flush), .hold(hold),
        .ex_rs(s_rs), .ex_rt(s_rt), .ex_rd(s_rd),
        .ex_a(s_a), .ex_b(s_b), .ex_imm(s_imm),
        .ex_reg_wen(s_reg_wen), .ex_mem_read(s_mem_read), .ex_mem_write(s_mem_write),
        .ex_mem_to_reg(s_mem_to_reg), .ex_alu_src(s_alu_src), .ex_alu_op(s_alu_op),
        .lu_stall(s_lu_stall), .stall_count(s_count)
    );

    // ctl packing: {reg_wen, mem_read, mem_write, mem_to_reg, alu_src, alu_op[3:0]}
    localparam logic [8:0] C_ADD = 9'h100;
    localparam logic [8:0] C_SUB = 9'h101;
    localparam logic [8:0] C_LW  = 9'h1B0;

    typedef struct {
        logic [4:0]  rs, rt, rd;
        logic        ur;
        logic [31:0] a;
        logic [8:0]  ctl;
        logic        fl, hd;
        logic        e_stall;
        logic [4:0]  e_rs, e_rt, e_rd;
        logic [31:0] e_a;
        logic [8:0]  e_ctl;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vt[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic ur, input logic [31:0] a, input logic [8:0] ctl,
                         input logic fl, input logic hd);
        id_rs = rs; id_rt = rt; id_rd = rd; id_uses_rt = ur;
        id_a = a; id_b = {a[15:0], a[31:16]}; id_imm = ~a;
        {id_reg_wen, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_alu_op} = ctl;
        flush = fl; hold = hd;
    endtask

    function automatic logic [8:0] ex_ctl();
        return {ex_reg_wen, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_alu_op};
    endfunction

    task automatic chk_ex(input string tag, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [31:0] a, input logic [8:0] ctl);
        chk({tag, ".ex_rs"}, 32'(ex_rs), 32'(rs));
        chk({tag, ".ex_rt"}, 32'(ex_rt), 32'(rt));
        chk({tag, ".ex_rd"}, 32'(ex_rd), 32'(rd));
        chk({tag, ".ex_a"}, ex_a, a);
        // Bubbles zero the data; otherwise b and imm follow the drive pattern.
        chk({tag, ".ex_b"}, ex_b, (a == 32'h0) ? 32'h0 : {a[15:0], a[31:16]});
        chk({tag, ".ex_imm"}, ex_imm, (a == 32'h0) ? 32'h0 : ~a);
        chk({tag, ".ctl"}, 32'(ex_ctl()), 32'(ctl));
    endtask

    initial begin
        //        rs  rt  rd  ur  a        ctl    fl  hd  stall e_rs e_rt e_rd e_a     e_ctl  cnt
        vt[0]  = '{5'd3, 5'd4, 5'd5,  1, 32'h11, C_ADD, 0, 0, 0, 5'd3, 5'd4, 5'd5,  32'h11, C_ADD, 16'd0};
        vt[1]  = '{5'd1, 5'd8, 5'd0,  0, 32'h20, C_LW,  0, 0, 0, 5'd1, 5'd8, 5'd0,  32'h20, C_LW,  16'd0};
        vt[2]  = '{5'd8, 5'd9, 5'd10, 1, 32'h30, C_ADD, 0, 0, 1, 5'd0, 5'd0, 5'd0,  32'h0,  9'h0,  16'd1};
        vt[3]  = '{5'd8, 5'd9, 5'd10, 1, 32'h30, C_ADD, 0, 0, 0, 5'd8, 5'd9, 5'd10, 32'h30, C_ADD, 16'd1};
        vt[4]  = '{5'd2, 5'd0, 5'd0,  0, 32'h40, C_LW,  0, 0, 0, 5'd2, 5'd0, 5'd0,  32'h40, C_LW,  16'd1};
        vt[5]  = '{5'd0, 5'd0, 5'd11, 1, 32'h50, C_ADD, 0, 0, 0, 5'd0, 5'd0, 5'd11, 32'h50, C_ADD, 16'd1};
        vt[6]  = '{5'd3, 5'd8, 5'd0,  0, 32'h60, C_LW,  0, 0, 0, 5'd3, 5'd8, 5'd0,  32'h60, C_LW,  16'd1};
        vt[7]  = '{5'd2, 5'd8, 5'd12, 0, 32'h70, C_ADD, 0, 0, 0, 5'd2, 5'd8, 5'd12, 32'h70, C_ADD, 16'd1};
        vt[8]  = '{5'd4, 5'd7, 5'd0,  0, 32'h80, C_LW,  0, 0, 0, 5'd4, 5'd7, 5'd0,  32'h80, C_LW,  16'd1};
        vt[9]  = '{5'd5, 5'd7, 5'd13, 1, 32'h90, C_SUB, 0, 0, 1, 5'd0, 5'd0, 5'd0,  32'h0,  9'h0,  16'd2};
        vt[10] = '{5'd5, 5'd7, 5'd13, 1, 32'h90, C_SUB, 0, 0, 0, 5'd5, 5'd7, 5'd13, 32'h90, C_SUB, 16'd2};
        vt[11] = '{5'd1, 5'd6, 5'd0,  0, 32'hA0, C_LW,  0, 0, 0, 5'd1, 5'd6, 5'd0,  32'hA0, C_LW,  16'd2};
        vt[12] = '{5'd6, 5'd1, 5'd14, 1, 32'hB0, C_ADD, 1, 0, 0, 5'd0, 5'd0, 5'd0,  32'h0,  9'h0,  16'd2};
        vt[13] = '{5'd1, 5'd6, 5'd0,  0, 32'hC0, C_LW,  0, 0, 0, 5'd1, 5'd6, 5'd0,  32'hC0, C_LW,  16'd2};
        vt[14] = '{5'd6, 5'd0, 5'd15, 0, 32'hD0, C_ADD, 0, 1, 0, 5'd1, 5'd6, 5'd0,  32'hC0, C_LW,  16'd2};
        vt[15] = '{5'd6, 5'd0, 5'd15, 0, 32'hD0, C_ADD, 0, 1, 0, 5'd1, 5'd6, 5'd0,  32'hC0, C_LW,  16'd2};
        vt[16] = '{5'd6, 5'd0, 5'd15, 0, 32'hD0, C_ADD, 0, 1, 0, 5'd1, 5'd6, 5'd0,  32'hC0, C_LW,  16'd2};
        vt[17] = '{5'd6, 5'd0, 5'd15, 0, 32'hD0, C_ADD, 0, 0, 1, 5'd0, 5'd0, 5'd0,  32'h0,  9'h0,  16'd3};
        vt[18] = '{5'd6, 5'd0, 5'd15, 0, 32'hD0, C_ADD, 0, 0, 0, 5'd6, 5'd0, 5'd15, 32'hD0, C_ADD, 16'd3};
        vt[19] = '{5'd9, 5'd9, 5'd9,  1, 32'hE0, C_SUB, 1, 1, 0, 5'd6, 5'd0, 5'd15, 32'hD0, C_ADD, 16'd3};

        rst_n = 1'b0;
        drive(5'd0, 5'd0, 5'd0, 0, 32'h0, 9'h0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk_ex("reset", 5'd0, 5'd0, 5'd0, 32'h0, 9'h0);
        chk("reset.lu_stall", 32'(lu_stall), 32'h0);
        chk("reset.stall_count", 32'(stall_count), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            drive(vt[i].rs, vt[i].rt, vt[i].rd, vt[i].ur, vt[i].a, vt[i].ctl, vt[i].fl, vt[i].hd);
            #1;
            chk($sformatf("v%0d.lu_stall", i), 32'(lu_stall), 32'(vt[i].e_stall));
            @(posedge clk);
            #1;
            chk_ex($sformatf("v%0d", i), vt[i].e_rs, vt[i].e_rt, vt[i].e_rd, vt[i].e_a, vt[i].e_ctl);
            chk($sformatf("v%0d.stall_count", i), 32'(stall_count), 32'(vt[i].e_cnt));
        end

        // Asynchronous reset in the middle of a load-use stall.
        drive(5'd1, 5'd8, 5'd0, 0, 32'h100, C_LW, 0, 0);
        @(posedge clk);
        #1;
        drive(5'd8, 5'd3, 5'd4, 1, 32'h200, C_ADD, 0, 0);
        #1;
        chk("mid_rst.pre_stall", 32'(lu_stall), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_ex("mid_rst", 5'd0, 5'd0, 5'd0, 32'h0, 9'h0);
        chk("mid_rst.lu_stall", 32'(lu_stall), 32'h0);
        chk("mid_rst.stall_count", 32'(stall_count), 32'h0);
        chk("mid_rst.sat_count", 32'(s_count), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_ex("post_rst", 5'd8, 5'd3, 5'd4, 32'h200, C_ADD);
        chk("post_rst.stall_count", 32'(stall_count), 32'h0);

        // Eight back-to-back load-use pairs: main counter counts, small one saturates.
        for (int k = 0; k < 8; k++) begin
            drive(5'd1, 5'd8, 5'd0, 0, 32'h300 + 32'(k), C_LW, 0, 0);
            @(posedge clk);
            #1;
            drive(5'd8, 5'd2, 5'd9, 1, 32'h400 + 32'(k), C_ADD, 0, 0);
            #1;
            chk($sformatf("sat%0d.lu_stall", k), 32'(lu_stall), 32'h1);
            @(posedge clk);
            #1;
        end
        chk("sat.stall_count", 32'(stall_count), 32'd8);
        chk("sat.sat_count", 32'(s_count), 32'd5);
        chk("sat.bubble_rd", 32'(ex_rd), 32'h0);
        chk("sat.bubble_wen", 32'(ex_reg_wen), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
